// File: rtl/relogio_expediente.sv
// relogio_expediente - HH:MM clock with time load handshake and business-hours flag.
// Define RELOGIO_EXPEDIENTE_SECONDS_EN to add a seconds counter and the second output.
module relogio_expediente #(
  parameter int TICKS_PER_MIN = 50,
  parameter int OPEN_HOUR     = 8,
  parameter int CLOSE_HOUR    = 18
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       set_req,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  output logic       set_ack,
  output logic       set_err,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic       expediente,
  output logic       day_end
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
  , output logic [5:0] second
`endif
);

`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
  localparam int DIV = ((TICKS_PER_MIN / 60) >= 1) ? (TICKS_PER_MIN / 60) : 1;
`else
  localparam int DIV = TICKS_PER_MIN;
`endif
  localparam int             PW       = $clog2(DIV + 1);
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
  localparam logic [4:0]     OPEN_H   = 5'(OPEN_HOUR);
  localparam logic [4:0]     CLOSE_H  = 5'(CLOSE_HOUR);

  typedef enum logic [1:0] {RUN, LOAD, HOLD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          day_end_q, day_end_d;
  logic          expediente_q;
  logic          min_tick;
  logic          load_ok;
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
  logic [5:0]    sec_q, sec_d;
`endif

  assign load_ok = (set_hour <= 5'd23) && (set_min <= 6'd59);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    hour_d    = hour_q;
    min_d     = min_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    day_end_d = 1'b0;
    min_tick  = 1'b0;
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
    sec_d     = sec_q;
`endif
    case (state_q)
      RUN: begin
        if (presc_q == PRE_LAST) begin
          presc_d = '0;
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
          if (sec_q == 6'd59) begin
            sec_d    = 6'd0;
            min_tick = 1'b1;
          end else begin
            sec_d = sec_q + 6'd1;
          end
`else
          min_tick = 1'b1;
`endif
        end else begin
          presc_d = presc_q + 1'b1;
        end
        // The tick of this cycle lands before a load request is serviced in LOAD.
        if (min_tick) begin
          if (min_q == 6'd59) begin
            min_d = 6'd0;
            if (hour_q == 5'd23) begin
              hour_d    = 5'd0;
              day_end_d = 1'b1;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end
        if (set_req) state_d = LOAD;
      end
      LOAD: begin
        state_d = HOLD;
        if (load_ok) begin
          hour_d  = set_hour;
          min_d   = set_min;
          presc_d = '0;
          ack_d   = 1'b1;
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
          sec_d   = 6'd0;
`endif
        end else begin
          err_d = 1'b1;
        end
      end
      HOLD: begin
        if (!set_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      presc_q      <= '0;
      hour_q       <= 5'd0;
      min_q        <= 6'd0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      day_end_q    <= 1'b0;
      expediente_q <= 1'b0;
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
      sec_q        <= 6'd0;
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      day_end_q    <= day_end_d;
      expediente_q <= (hour_d >= OPEN_H) && (hour_d < CLOSE_H);
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
      sec_q        <= sec_d;
`endif
    end
  end

  assign set_ack    = ack_q;
  assign set_err    = err_q;
  assign hour       = hour_q;
  assign minute     = min_q;
  assign expediente = expediente_q;
  assign day_end    = day_end_q;
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
  assign second     = sec_q;
`endif

endmodule

// File: tb/tb_relogio_expediente.sv
// tb/tb_relogio_expediente.sv - scoreboard bench for relogio_expediente.
// Honors RELOGIO_EXPEDIENTE_SECONDS_EN (runs with TICKS_PER_MIN=120 when defined).
module tb_relogio_expediente;

`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
  localparam int TPM = 120;
  localparam int DIV = ((TPM / 60) >= 1) ? (TPM / 60) : 1;
  localparam int MC  = DIV * 60;
`else
  localparam int TPM = 50;
  localparam int DIV = TPM;
  localparam int MC  = TPM;
`endif

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       set_req = 1'b0;
  logic [4:0] set_hour = 5'd0;
  logic [5:0] set_min = 6'd0;
  logic       set_ack, set_err, expediente, day_end;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] sec_obs;

  relogio_expediente #(.TICKS_PER_MIN(TPM), .OPEN_HOUR(8), .CLOSE_HOUR(18)) dut (
    .clk_2(clk_2), .reset(reset), .set_req(set_req), .set_hour(set_hour),
    .set_min(set_min), .set_ack(set_ack), .set_err(set_err), .hour(hour),
    .minute(minute), .expediente(expediente), .day_end(day_end)
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
    , .second(sec_obs)
`endif
  );
`ifndef RELOGIO_EXPEDIENTE_SECONDS_EN
  assign sec_obs = 6'd0;
`endif

  always #5 clk_2 = ~clk_2;

  int n_vec = 0;
  int n_bad = 0;
  int ack_seen = 0, err_seen = 0, de_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the clock, stepped once per rising edge.
  int m_state, m_pre, m_sec, m_hour, m_min;
  bit m_ack, m_err, m_de, m_exp;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_state = 0; m_pre = 0; m_sec = 0; m_hour = 0; m_min = 0;
    m_ack = 0; m_err = 0; m_de = 0; m_exp = 0;
  endtask

  task automatic model_step();
    bit mt;
    mt = 0; m_ack = 0; m_err = 0; m_de = 0;
    case (m_state)
      0: begin
        m_pre++;
        if (m_pre == DIV) begin
          m_pre = 0;
`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
          m_sec++;
          if (m_sec == 60) begin m_sec = 0; mt = 1; end
`else
          mt = 1;
`endif
        end
        if (mt) begin
          m_min++;
          if (m_min == 60) begin
            m_min = 0; m_hour++;
            if (m_hour == 24) begin m_hour = 0; m_de = 1; end
          end
        end
        if (set_req) m_state = 1;
      end
      1: begin
        if (set_hour < 24 && set_min < 60) begin
          m_hour = set_hour; m_min = set_min; m_pre = 0; m_sec = 0; m_ack = 1;
        end else begin
          m_err = 1;
        end
        m_state = 2;
      end
      default: if (!set_req) m_state = 0;
    endcase
    m_exp = (m_hour >= 8) && (m_hour < 18);
  endtask

  function automatic logic [31:0] model_pack();
    return {11'd0, 6'(m_sec), m_ack, m_err, 5'(m_hour), 6'(m_min), m_exp, m_de};
  endfunction

  function automatic logic [31:0] dut_pack();
    return {11'd0, sec_obs, set_ack, set_err, hour, minute, expediente, day_end};
  endfunction

  task automatic cycle();
    model_step();
    exp_q.push_back(model_pack());
    @(posedge clk_2);
    #1;
    check_val("cycle", dut_pack(), exp_q.pop_front());
    if (set_ack) ack_seen++;
    if (set_err) err_seen++;
    if (day_end) de_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr_counts();
    ack_seen = 0; err_seen = 0; de_seen = 0;
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m);
    set_hour = h; set_min = m; set_req = 1'b1;
    run(2);
    set_req = 1'b0;
    run(1);
  endtask

  initial begin
    model_reset();
    @(posedge clk_2); #1;
    check_val("reset_state", dut_pack(), 32'd0);
    reset = 1'b1;

    // Eight hours from midnight: expediente rises with hour 8.
    run(MC * 60 * 8 - 1);
    check_val("h7_hour", hour, 5'd7);
    check_val("h7_min", minute, 6'd59);
    check_val("h7_exp", expediente, 1'b0);
    run(1);
    check_val("h8_hour", hour, 5'd8);
    check_val("h8_min", minute, 6'd0);
    check_val("h8_exp", expediente, 1'b1);

    // Load 23:59 and roll over midnight.
    clr_counts();
    do_load(5'd23, 6'd59);
    check_val("load2359_ack", ack_seen, 1);
    run(MC);
    check_val("roll_hour", hour, 5'd0);
    check_val("roll_min", minute, 6'd0);
    check_val("roll_exp", expediente, 1'b0);
    check_val("roll_day_end_cnt", de_seen, 1);
    run(1);
    check_val("day_end_drop", day_end, 1'b0);

    // Invalid load held for a while.
    clr_counts();
    set_hour = 5'd24; set_min = 6'd10; set_req = 1'b1;
    run(20);
    check_val("bad_err_cnt", err_seen, 1);
    check_val("bad_ack_cnt", ack_seen, 0);
    check_val("bad_hour", hour, 5'd0);
    check_val("bad_min", minute, 6'd0);
    set_req = 1'b0;
    run(1);

    // Load 17:59 with set_req held 100 cycles.
    clr_counts();
    set_hour = 5'd17; set_min = 6'd59; set_req = 1'b1;
    run(102);
    check_val("hold_ack_cnt", ack_seen, 1);
    check_val("hold_hour", hour, 5'd17);
    check_val("hold_min", minute, 6'd59);
    check_val("hold_exp", expediente, 1'b1);
    set_req = 1'b0;
    run(1);
    set_hour = 5'd3; set_min = 6'd3;
    run(MC);
    check_val("h18_hour", hour, 5'd18);
    check_val("h18_min", minute, 6'd0);
    check_val("h18_exp", expediente, 1'b0);

`ifdef RELOGIO_EXPEDIENTE_SECONDS_EN
    run(5);
    check_val("sec_count", sec_obs, 6'd2);
    do_load(5'd10, 6'd0);
    check_val("sec_cleared", sec_obs, 6'd0);
    run(2);
    check_val("sec_step", sec_obs, 6'd1);
`endif

    // Reset asserted while holding after a 12:30 load.
    clr_counts();
    set_hour = 5'd12; set_min = 6'd30; set_req = 1'b1;
    run(4);
    check_val("pre_rst_hour", hour, 5'd12);
    check_val("pre_rst_ack", ack_seen, 1);
    #2 reset = 1'b0;
    #1;
    check_val("async_rst", dut_pack(), 32'd0);
    model_reset();
    @(posedge clk_2); #1;
    check_val("rst_hold", dut_pack(), 32'd0);
    set_req = 1'b0;
    reset = 1'b1;
    clr_counts();
    run(3);
    check_val("post_rst_ack", ack_seen, 0);
    check_val("post_rst_hour", hour, 5'd0);
    check_val("post_rst_min", minute, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/relogio_expediente.md
RELOGIO_EXPEDIENTE -- requirements
Module: relogio_expediente

Interface
REQ-001 Parameter TICKS_PER_MIN, default 50, sets the number of clk_2 cycles per minute; legal range 2..2^26.
REQ-002 Parameter OPEN_HOUR, default 8, sets the first hour of business hours.
REQ-003 Parameter CLOSE_HOUR, default 18, sets the first hour outside business hours; OPEN_HOUR < CLOSE_HOUR <= 24.
REQ-004 clk_2  input  1  is the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  is an asynchronous, active-low reset.
REQ-006 set_req  input  1  is a time-load request, level-held until set_ack.
REQ-007 set_hour  input  5  is the hour to load.
REQ-008 set_min  input  6  is the minute to load.
REQ-009 set_ack  output  1  is a one-cycle acknowledge of an accepted load.
REQ-010 set_err  output  1  is a one-cycle flag for a rejected load.
REQ-011 hour  output  5  is the current hour, 0..23.
REQ-012 minute  output  6  is the current minute, 0..59.
REQ-013 expediente  output  1  is the registered business-hours flag that drives the alarm clock input.
REQ-014 day_end  output  1  is a one-cycle pulse on the 23:59->00:00 rollover.

Function
REQ-015 The block SHALL implement an FSM with states RUN, LOAD and HOLD.
- RUN: counting.
- LOAD: one cycle, load handling.
- HOLD: waits for set_req to go low.
REQ-016 In RUN, a prescaler SHALL count 0..TICKS_PER_MIN-1, and each wrap SHALL produce one minute tick.
REQ-017 On a minute tick, minute SHALL increment; at 59 it SHALL wrap to 0 and increment hour; 23:59 SHALL wrap to 00:00 and pulse day_end for exactly that cycle.
REQ-018 expediente SHALL be 1 iff OPEN_HOUR <= hour < CLOSE_HOUR, updated in the same cycle as the hour register (no extra latency).
REQ-019 RUN SHALL go to LOAD on the first cycle set_req=1.
- In LOAD, if set_hour<=23 and set_min<=59: load both, clear the prescaler, pulse set_ack.
- Otherwise: keep the time, pulse set_err.
REQ-020 LOAD SHALL go to HOLD and then back to RUN only once set_req=0, so one request yields exactly one ack or err.
REQ-021 Counting SHALL pause in LOAD and HOLD; the prescaler SHALL hold its value in HOLD.
REQ-022 If set_req rises in the same cycle as a minute tick, the tick SHALL be applied first; a valid load then overwrites it in LOAD.
REQ-023 set_ack and set_err SHALL never be asserted together.
REQ-024 set_hour and set_min SHALL be sampled only in LOAD; changes in HOLD SHALL be ignored.

Reset
REQ-025 While reset=0 the block SHALL asynchronously force:
- state=RUN, prescaler=0, hour=0, minute=0;
- expediente=0, day_end=0, set_ack=0, set_err=0.
REQ-026 Reset asserted during LOAD or HOLD SHALL abandon the request with no ack or err; after release, a still-high set_req SHALL start a new request.
REQ-027 Counting SHALL resume on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro RELOGIO_EXPEDIENTE_SECONDS_EN SHALL control the seconds counter.
- Defined: add output second[5:0]; the prescaler wraps at TICKS_PER_MIN/60 cycles, rounded down, minimum 1, and increments second; 59->0 generates the minute tick. A valid load and reset both clear second.
- Undefined: no second port; minute ticks come directly from the prescaler per REQ-016.

Verification
REQ-029 Reset, then 50*60*8 cycles, macro off -> hour=8, minute=0, expediente=1 rising the same cycle hour becomes 8.
REQ-030 Load 23:59 then 50 cycles -> hour=0, minute=0, day_end high exactly 1 cycle, expediente=0.
REQ-031 set_req with set_hour=24, set_min=10 -> set_err 1 cycle, set_ack stays 0, time unchanged, no second err while set_req is held.
REQ-032 Load 17:59 and hold set_req high 100 cycles -> one set_ack, time frozen at 17:59; release set_req, then 50 cycles -> 18:00, expediente falls to 0.
REQ-033 Drop reset to 0 while in HOLD after loading 12:30 -> outputs zero immediately (asynchronous), no further ack, 00:00 after release.
REQ-034 Macro on, TICKS_PER_MIN=120 -> second increments every 2 cycles; minute increments after 120 cycles; a load clears second to 0.
